// File: rtl/iic_arbiter.sv
// -----------------------------------------------------------------------------
// iic_arbiter
//
// Shares one IIC master between two command sources. Port 0 and port 1 are
// arbitrated round-robin. The winning command is latched onto the master's
// command bus, and iic_start is held high until the master reports
// completion. Read data, the done pulse and the error flag are returned only
// to the port that won.
//
// Sequence: IDLE (capture + ack) -> ISSUE (raise start) -> WAIT -> DONE -> IDLE
//
// Optional feature: define IIC_ARB_TIMEOUT_EN to abort a WAIT that lasts
// TIMEOUT_CYC cycles. The aborted transaction finishes with reqN_err = 1.
// Without the macro, WAIT holds indefinitely and reqN_err is tied to 0.
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   reqN_valid_i           port N command pending (held until reqN_ack_o)
//   reqN_wr_i              1 = write, 0 = read
//   reqN_addr_mem_i        1 = 16-bit register address, 0 = 8-bit
//   reqN_addr_i[15:0]      register address
//   reqN_wdata_i[7:0]      write data
//   reqN_ack_o             one-cycle pulse: command captured
//   reqN_done_o            one-cycle pulse: transaction finished
//   reqN_rdata_o[7:0]      read data, held until the next read on that port
//   reqN_err_o             with reqN_done_o: 1 = timed out
//   iic_start_o            level start to master
//   wr_en_o, rd_en_o       transaction type to master
//   addr_mem_o             address width to master
//   data_addr_o[15:0]      register address to master
//   wr_data_o[7:0]         write data to master
//   iic_wr_rd_done_i       master completion (pulse or level)
//   iic_rd_data_i[7:0]     master read data, valid with completion
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module iic_arbiter #(
  parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid_i,
  input  logic        req0_wr_i,
  input  logic        req0_addr_mem_i,
  input  logic [15:0] req0_addr_i,
  input  logic [7:0]  req0_wdata_i,
  output logic        req0_ack_o,
  output logic        req0_done_o,
  output logic [7:0]  req0_rdata_o,
  output logic        req0_err_o,
  input  logic        req1_valid_i,
  input  logic        req1_wr_i,
  input  logic        req1_addr_mem_i,
  input  logic [15:0] req1_addr_i,
  input  logic [7:0]  req1_wdata_i,
  output logic        req1_ack_o,
  output logic        req1_done_o,
  output logic [7:0]  req1_rdata_o,
  output logic        req1_err_o,
  output logic        iic_start_o,
  output logic        wr_en_o,
  output logic        rd_en_o,
  output logic        addr_mem_o,
  output logic [15:0] data_addr_o,
  output logic [7:0]  wr_data_o,
  input  logic        iic_wr_rd_done_i,
  input  logic [7:0]  iic_rd_data_i
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]  state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic        grant_q, grant_d;       // port being served
  logic        cmd_wr_q, cmd_wr_d;     // type of the captured command
  logic        start_q, start_d;
  logic        wr_en_q, wr_en_d;
  logic        rd_en_q, rd_en_d;
  logic        addr_mem_q, addr_mem_d;
  logic [15:0] data_addr_q, data_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic [1:0]  ack_q, ack_d;
  logic [1:0]  done_q, done_d;
  logic [7:0]  rdata0_q, rdata0_d;
  logic [7:0]  rdata1_q, rdata1_d;
  logic        pick1;
  logic        timed_out;

  // Port 1 wins when it is the only requester, or when both request and
  // port 1 did not win last time.
  assign pick1 = req1_valid_i & (~req0_valid_i | ~last_grant_q);

`ifdef IIC_ARB_TIMEOUT_EN
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYC - 1);
  logic [31:0] tmo_cnt_q, tmo_cnt_d;
  logic [1:0]  err_q, err_d;
  assign timed_out = (tmo_cnt_q == TMO_LAST);
`else
  assign timed_out = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    cmd_wr_d     = cmd_wr_q;
    start_d      = start_q;
    wr_en_d      = wr_en_q;
    rd_en_d      = rd_en_q;
    addr_mem_d   = addr_mem_q;
    data_addr_d  = data_addr_q;
    wr_data_d    = wr_data_q;
    ack_d        = 2'b00;
    done_d       = 2'b00;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
`ifdef IIC_ARB_TIMEOUT_EN
    tmo_cnt_d    = tmo_cnt_q;
    err_d        = 2'b00;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req0_valid_i | req1_valid_i) begin
          grant_d     = pick1;
          ack_d       = pick1 ? 2'b10 : 2'b01;
          cmd_wr_d    = pick1 ? req1_wr_i       : req0_wr_i;
          addr_mem_d  = pick1 ? req1_addr_mem_i : req0_addr_mem_i;
          data_addr_d = pick1 ? req1_addr_i     : req0_addr_i;
          wr_data_d   = pick1 ? req1_wdata_i    : req0_wdata_i;
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        start_d = 1'b1;
        wr_en_d = cmd_wr_q;
        rd_en_d = ~cmd_wr_q;
`ifdef IIC_ARB_TIMEOUT_EN
        tmo_cnt_d = '0;
`endif
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // Completion takes priority over a timeout in the same cycle.
        if (iic_wr_rd_done_i | timed_out) begin
          start_d      = 1'b0;
          wr_en_d      = 1'b0;
          rd_en_d      = 1'b0;
          last_grant_d = grant_q;
          done_d       = grant_q ? 2'b10 : 2'b01;
          if (iic_wr_rd_done_i & ~cmd_wr_q) begin
            if (grant_q) rdata1_d = iic_rd_data_i;
            else         rdata0_d = iic_rd_data_i;
          end
`ifdef IIC_ARB_TIMEOUT_EN
          err_d = iic_wr_rd_done_i ? 2'b00 : done_d;
`endif
          state_d = ST_DONE;
        end
`ifdef IIC_ARB_TIMEOUT_EN
        else begin
          tmo_cnt_d = tmo_cnt_q + 32'd1;
        end
`endif
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      cmd_wr_q     <= 1'b0;
      start_q      <= 1'b0;
      wr_en_q      <= 1'b0;
      rd_en_q      <= 1'b0;
      addr_mem_q   <= 1'b1;
      data_addr_q  <= '0;
      wr_data_q    <= '0;
      ack_q        <= '0;
      done_q       <= '0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      cmd_wr_q     <= cmd_wr_d;
      start_q      <= start_d;
      wr_en_q      <= wr_en_d;
      rd_en_q      <= rd_en_d;
      addr_mem_q   <= addr_mem_d;
      data_addr_q  <= data_addr_d;
      wr_data_q    <= wr_data_d;
      ack_q        <= ack_d;
      done_q       <= done_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
    end
  end

`ifdef IIC_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_q <= '0;
      err_q     <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      err_q     <= err_d;
    end
  end
  assign req0_err_o = err_q[0];
  assign req1_err_o = err_q[1];
`else
  assign req0_err_o = 1'b0;
  assign req1_err_o = 1'b0;
`endif

  assign req0_ack_o   = ack_q[0];
  assign req1_ack_o   = ack_q[1];
  assign req0_done_o  = done_q[0];
  assign req1_done_o  = done_q[1];
  assign req0_rdata_o = rdata0_q;
  assign req1_rdata_o = rdata1_q;
  assign iic_start_o  = start_q;
  assign wr_en_o      = wr_en_q;
  assign rd_en_o      = rd_en_q;
  assign addr_mem_o   = addr_mem_q;
  assign data_addr_o  = data_addr_q;
  assign wr_data_o    = wr_data_q;

endmodule

// File: tb/tb_iic_arbiter.sv
`timescale 1ns/1ps
module tb_iic_arbiter;

  localparam int TMO_CYC = 16;
`ifdef IIC_ARB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
  localparam int LAT_A  = 10;
`else
  localparam bit TMO_EN = 1'b0;
  localparam int LAT_A  = 50;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req0_valid_i = 1'b0, req0_wr_i = 1'b0, req0_addr_mem_i = 1'b0;
  logic [15:0] req0_addr_i = '0;
  logic [7:0]  req0_wdata_i = '0;
  logic        req1_valid_i = 1'b0, req1_wr_i = 1'b0, req1_addr_mem_i = 1'b0;
  logic [15:0] req1_addr_i = '0;
  logic [7:0]  req1_wdata_i = '0;
  logic        iic_wr_rd_done_i = 1'b0;
  logic [7:0]  iic_rd_data_i = '0;
  logic        req0_ack_o, req0_done_o, req0_err_o;
  logic        req1_ack_o, req1_done_o, req1_err_o;
  logic [7:0]  req0_rdata_o, req1_rdata_o;
  logic        iic_start_o, wr_en_o, rd_en_o, addr_mem_o;
  logic [15:0] data_addr_o;
  logic [7:0]  wr_data_o;

  always #5 clk = ~clk;

  iic_arbiter #(.TIMEOUT_CYC(TMO_CYC)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid_i(req0_valid_i), .req0_wr_i(req0_wr_i), .req0_addr_mem_i(req0_addr_mem_i),
    .req0_addr_i(req0_addr_i), .req0_wdata_i(req0_wdata_i),
    .req0_ack_o(req0_ack_o), .req0_done_o(req0_done_o), .req0_rdata_o(req0_rdata_o),
    .req0_err_o(req0_err_o),
    .req1_valid_i(req1_valid_i), .req1_wr_i(req1_wr_i), .req1_addr_mem_i(req1_addr_mem_i),
    .req1_addr_i(req1_addr_i), .req1_wdata_i(req1_wdata_i),
    .req1_ack_o(req1_ack_o), .req1_done_o(req1_done_o), .req1_rdata_o(req1_rdata_o),
    .req1_err_o(req1_err_o),
    .iic_start_o(iic_start_o), .wr_en_o(wr_en_o), .rd_en_o(rd_en_o),
    .addr_mem_o(addr_mem_o), .data_addr_o(data_addr_o), .wr_data_o(wr_data_o),
    .iic_wr_rd_done_i(iic_wr_rd_done_i), .iic_rd_data_i(iic_rd_data_i)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired, required event never seen (t=%0t)", name, $time);
  endtask

  // ---------------------------------------------------------------------------
  // Transaction-level reference model. A transaction is a timeline measured
  // in edges from its capture: ack right after capture, start one edge later,
  // completion accepted from the following edge on, then one quiet edge.
  // ---------------------------------------------------------------------------
  logic       m_busy, m_cool, m_wr, m_last, m_port;
  int         m_age;
  logic [1:0] e_ack, e_done, e_err;
  logic [7:0] e_rdata [2];
  logic       e_start, e_wr_en, e_rd_en, e_addr_mem;
  logic [15:0] e_addr;
  logic [7:0] e_wdata;

  task automatic model_reset();
    m_busy = 1'b0; m_cool = 1'b0; m_wr = 1'b0; m_last = 1'b1; m_port = 1'b0; m_age = 0;
    e_ack = '0; e_done = '0; e_err = '0; e_rdata[0] = '0; e_rdata[1] = '0;
    e_start = 1'b0; e_wr_en = 1'b0; e_rd_en = 1'b0; e_addr_mem = 1'b1;
    e_addr = '0; e_wdata = '0;
  endtask

  task automatic model_finish(input logic tmo);
    m_busy = 1'b0; m_cool = 1'b1; m_last = m_port;
    e_done[m_port] = 1'b1; e_err[m_port] = tmo;
    e_start = 1'b0; e_wr_en = 1'b0; e_rd_en = 1'b0;
    if (!tmo && !m_wr) e_rdata[m_port] = iic_rd_data_i;
  endtask

  // Predicts outputs after the coming edge from the inputs that edge samples.
  task automatic model_step();
    logic w;
    e_ack = '0; e_done = '0; e_err = '0;
    if (m_cool) m_cool = 1'b0;
    else if (!m_busy) begin
      if (req0_valid_i || req1_valid_i) begin
        w = (req0_valid_i && req1_valid_i) ? ~m_last : req1_valid_i;
        m_busy = 1'b1; m_port = w; m_age = 0; e_ack[w] = 1'b1;
        m_wr       = w ? req1_wr_i       : req0_wr_i;
        e_addr_mem = w ? req1_addr_mem_i : req0_addr_mem_i;
        e_addr     = w ? req1_addr_i     : req0_addr_i;
        e_wdata    = w ? req1_wdata_i    : req0_wdata_i;
      end
    end else if (m_age == 0) begin
      m_age = 1; e_start = 1'b1; e_wr_en = m_wr; e_rd_en = !m_wr;
    end else if (iic_wr_rd_done_i) model_finish(1'b0);
    else if (TMO_EN && m_age == TMO_CYC) model_finish(1'b1);
    else m_age++;
  endtask

  // Single compare process: every falling edge, outputs vs. model.
  initial begin
    model_reset();
    forever begin
      @(negedge clk);
      if (!rst_n) model_reset();
      chk("req0_ack", req0_ack_o, e_ack[0]);
      chk("req1_ack", req1_ack_o, e_ack[1]);
      chk("req0_done", req0_done_o, e_done[0]);
      chk("req1_done", req1_done_o, e_done[1]);
      chk("req0_err", req0_err_o, e_err[0]);
      chk("req1_err", req1_err_o, e_err[1]);
      chk("req0_rdata", req0_rdata_o, e_rdata[0]);
      chk("req1_rdata", req1_rdata_o, e_rdata[1]);
      chk("iic_start", iic_start_o, e_start);
      chk("wr_en", wr_en_o, e_wr_en);
      chk("rd_en", rd_en_o, e_rd_en);
      chk("addr_mem", addr_mem_o, e_addr_mem);
      chk("data_addr", data_addr_o, e_addr);
      chk("wr_data", wr_data_o, e_wdata);
      if (rst_n) model_step();
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (inputs change 2 ns after the rising edge)
  // ---------------------------------------------------------------------------
  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic wait_ack(output int g);
    int n = 0;
    while (!(req0_ack_o || req1_ack_o) && n < 20) begin tick(1); n++; end
    if (req0_ack_o || req1_ack_o) g = req1_ack_o ? 1 : 0;
    else begin g = -1; bound_fail("ack_wait"); end
  endtask

  task automatic wait_start();
    int n = 0;
    while (!iic_start_o && n < 20) begin tick(1); n++; end
    if (!iic_start_o) bound_fail("start_wait");
  endtask

  task automatic finish_txn(input int g);
    wait_start();
    tick(2);
    iic_wr_rd_done_i = 1'b1;
    tick(1);
    iic_wr_rd_done_i = 1'b0;
    if (g >= 0) chk("txn_done_pulse", (g == 1) ? req1_done_o : req0_done_o, 1);
  endtask

  task automatic run_one(output int g);
    wait_ack(g);
    finish_txn(g);
  endtask

  task automatic rnd_cmd(output logic wr, output logic am, output logic [15:0] a,
                         output logic [7:0] d);
    wr = 1'($urandom); am = 1'($urandom); a = 16'($urandom); d = 8'($urandom);
  endtask

  initial begin
    int g;
    int n;
    int lat;
    int linger;
    int order [4];

    #1 rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    chk("rst_addr_mem", addr_mem_o, 1);
    chk("rst_start", iic_start_o, 0);
    chk("rst_acks", {req1_ack_o, req0_ack_o}, 0);
    tick(2);

    // Port 0 write 0x005A <- 0x55
    req0_valid_i = 1'b1; req0_wr_i = 1'b1; req0_addr_mem_i = 1'b1;
    req0_addr_i = 16'h005A; req0_wdata_i = 8'h55;
    tick(1);
    chk("a_ack0", req0_ack_o, 1);
    req0_valid_i = 1'b0;
    chk("a_data_addr", data_addr_o, 16'h005A);
    chk("a_wr_data", wr_data_o, 8'h55);
    tick(1);
    chk("a_start", iic_start_o, 1);
    chk("a_wr_en", wr_en_o, 1);
    tick(LAT_A);
    chk("a_start_held", iic_start_o, 1);
    iic_wr_rd_done_i = 1'b1;
    tick(1);
    iic_wr_rd_done_i = 1'b0;
    chk("a_done0", req0_done_o, 1);
    chk("a_err0", req0_err_o, 0);
    chk("a_start_low", iic_start_o, 0);
    tick(1);

    // Port 1 read 0x005A -> 0xA5
    req1_valid_i = 1'b1; req1_wr_i = 1'b0; req1_addr_mem_i = 1'b0; req1_addr_i = 16'h005A;
    tick(1);
    chk("b_ack1", req1_ack_o, 1);
    chk("b_ack0", req0_ack_o, 0);
    req1_valid_i = 1'b0;
    tick(1);
    chk("b_rd_en", rd_en_o, 1);
    tick(5);
    iic_wr_rd_done_i = 1'b1; iic_rd_data_i = 8'hA5;
    tick(1);
    iic_wr_rd_done_i = 1'b0; iic_rd_data_i = 8'h00;
    chk("b_done1", req1_done_o, 1);
    chk("b_rdata1", req1_rdata_o, 8'hA5);
    chk("b_done0", req0_done_o, 0);
    tick(1);
    chk("b_rdata1_held", req1_rdata_o, 8'hA5);

    // Both valid right after reset, held continuously: 0,1,0,1
    rst_n = 1'b0; tick(2); rst_n = 1'b1;
    req0_valid_i = 1'b1; req1_valid_i = 1'b1;
    for (int i = 0; i < 4; i++) run_one(order[i]);
    for (int i = 0; i < 4; i++) chk("c_grant_order", order[i], i % 2);

    // Port 0 alone, then reset while port 1 is in WAIT
    req1_valid_i = 1'b0;
    run_one(g);
    chk("d_port0_alone", g, 0);
    req0_valid_i = 1'b0; req1_valid_i = 1'b1;
    wait_ack(g);
    chk("d_port1_grant", g, 1);
    wait_start();
    tick(3);
    rst_n = 1'b0;
    #1;
    chk("d_start_async_low", iic_start_o, 0);
    tick(2);
    chk("d_no_done", {req1_done_o, req0_done_o}, 0);
    rst_n = 1'b1;
    req0_valid_i = 1'b1;
    wait_ack(g);
    chk("d_post_reset_grant", g, 0);
    finish_txn(g);
    req0_valid_i = 1'b0; req1_valid_i = 1'b0;

    // Stray completion while idle
    tick(3);
    iic_wr_rd_done_i = 1'b1;
    tick(1);
    iic_wr_rd_done_i = 1'b0;
    chk("e_stray_done", {req1_done_o, req0_done_o}, 0);
    chk("e_stray_start", iic_start_o, 0);
    tick(2);
    req1_valid_i = 1'b1; req1_wr_i = 1'b1; req1_addr_i = 16'h1234; req1_wdata_i = 8'h3C;
    run_one(g);
    chk("e_after_stray", g, 1);
    req1_valid_i = 1'b0;

`ifdef IIC_ARB_TIMEOUT_EN
    tick(2);
    req0_valid_i = 1'b1; req0_wr_i = 1'b0;
    wait_ack(g);
    req0_valid_i = 1'b0;
    wait_start();
    n = 0;
    while (!req0_done_o && n < 40) begin tick(1); n++; end
    chk("t_wait_cycles", n, TMO_CYC);
    chk("t_err0", req0_err_o, 1);
    tick(1);
    req1_valid_i = 1'b1;
    run_one(g);
    chk("t_next_grant", g, 1);
    chk("t_next_err", req1_err_o, 0);
    req1_valid_i = 1'b0;
`endif

    // Randomized traffic against the model
    lat = 0; linger = 0;
    for (int c = 0; c < 4000; c++) begin
      tick(1);
      if (!rst_n) begin
        if ($urandom_range(0, 1) == 0) rst_n = 1'b1;
      end else if ($urandom_range(0, 499) == 0) rst_n = 1'b0;

      if (req0_valid_i && req0_ack_o) begin
        if ($urandom_range(0, 1) == 0) rnd_cmd(req0_wr_i, req0_addr_mem_i, req0_addr_i, req0_wdata_i);
        else req0_valid_i = 1'b0;
      end else if (!req0_valid_i && $urandom_range(0, 3) == 0) begin
        rnd_cmd(req0_wr_i, req0_addr_mem_i, req0_addr_i, req0_wdata_i);
        req0_valid_i = 1'b1;
      end
      if (req1_valid_i && req1_ack_o) begin
        if ($urandom_range(0, 1) == 0) rnd_cmd(req1_wr_i, req1_addr_mem_i, req1_addr_i, req1_wdata_i);
        else req1_valid_i = 1'b0;
      end else if (!req1_valid_i && $urandom_range(0, 3) == 0) begin
        rnd_cmd(req1_wr_i, req1_addr_mem_i, req1_addr_i, req1_wdata_i);
        req1_valid_i = 1'b1;
      end

      if (iic_start_o) begin
        if (!iic_wr_rd_done_i) begin
          if (lat == 0) begin
            iic_wr_rd_done_i = 1'b1;
            linger = $urandom_range(0, 2);
          end else lat--;
        end
      end else begin
        if (iic_wr_rd_done_i && linger > 0) linger--;
        else iic_wr_rd_done_i = ($urandom_range(0, 19) == 0);
        lat = ($urandom_range(0, 3) == 0) ? $urandom_range(10, 25) : $urandom_range(0, 6);
      end
      iic_rd_data_i = 8'($urandom);
    end

    req0_valid_i = 1'b0; req1_valid_i = 1'b0; iic_wr_rd_done_i = 1'b0; rst_n = 1'b1;
    tick(4);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/iic_arbiter.md
# iic_arbiter

Two-port arbiter and sequencer sharing the single IIC master between two command sources (e.g. key-driven test FSM on port 0, EEPROM logger on port 1). Captures one command at a time using round-robin arbitration, drives the master's command bus and start level, and waits for the master's completion. It returns read data, completion and an optional timeout error to the winning requester only.

## Interface
- TIMEOUT_CYC, 1_000_000: WAIT-state cycle limit (20 ms at 50 MHz); used only when the timeout feature is compiled in.
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- reqN_valid  in  1  port N (N = 0,1) command pending; held until reqN_ack
- reqN_wr  in  1  1 = write, 0 = read
- reqN_addr_mem  in  1  1 = 16-bit register address, 0 = 8-bit
- reqN_addr  in  16  register address
- reqN_wdata  in  8  write data (ignored for reads)
- reqN_ack  out  1  one-cycle pulse; command captured
- reqN_done  out  1  one-cycle pulse; transaction finished
- reqN_rdata  out  8  read data, valid while reqN_done is high and held after
- reqN_err  out  1  valid with reqN_done; 1 = timed out
- iic_start  out  1  level start to master, held until completion
- wr_en, rd_en  out  1  transaction type to master
- addr_mem  out  1  address width to master
- data_addr  out  16  register address to master
- wr_data  out  8  write data to master
- iic_wr_rd_done  in  1  master completion (pulse or level)
- iic_rd_data  in  8  master read data, valid with iic_wr_rd_done

## Operation
- Reset values:
  - All outputs are 0, except addr_mem = 1.
  - State = IDLE.
  - Timeout counter = 0.
  - last_grant = 1, so port 0 wins the first contest.
- States: IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
- IDLE:
  - If any reqN_valid is high, select the winner, latch its fields into the master command registers and pulse reqN_ack.
  - Go to ISSUE.
  - If no request is valid, stay in IDLE.
- Arbitration:
  - Single valid port wins.
  - If both ports are valid, the port that is not last_grant wins.
  - last_grant updates on entry to DONE.
- ISSUE:
  - Assert iic_start.
  - Drive wr_en = wr and rd_en = ~wr.
  - Go to WAIT.
- WAIT:
  - Hold iic_start and the command bus stable.
  - On iic_wr_rd_done high:
    - Clear iic_start, wr_en and rd_en.
    - If the transaction was a read, capture iic_rd_data into the winner's reqN_rdata.
    - Pulse the winner's reqN_done with reqN_err = 0.
    - Go to DONE.
- DONE:
  - One cycle with no new acceptance.
  - Go to IDLE.
- The loser keeps reqN_valid asserted and is served on the next arbitration.
- The ack/done outputs of the non-granted port stay 0 throughout the transaction.
- iic_wr_rd_done outside WAIT is ignored.
- Reset mid-transaction: all outputs go to reset values immediately and the transaction is abandoned; no done or error pulse is issued.
- reqN_rdata keeps its last value until the next read completes on that port.

## Timing
- reqN_valid sampled high at edge k in IDLE:
  - reqN_ack is high during cycle k+1.
  - iic_start goes high at edge k+2.
- iic_wr_rd_done sampled at edge m:
  - iic_start falls at edge m+1.
  - reqN_done is high for cycle m+1.
- Minimum gap from done to the next ack is 2 cycles, guaranteeing at least one iic_start low cycle between transactions.
- Minimum overhead per command is 4 cycles plus master latency.

## Configuration
- IIC_ARB_TIMEOUT_EN defined:
  - A 32-bit counter clears on entry to WAIT and increments each WAIT cycle.
  - When the count reaches TIMEOUT_CYC-1 without completion:
    - Clear iic_start, wr_en and rd_en.
    - Pulse reqN_done with reqN_err = 1; reqN_rdata is unchanged.
    - Go to DONE.
  - If completion and timeout occur in the same cycle, completion wins (err = 0).
- IIC_ARB_TIMEOUT_EN undefined:
  - WAIT holds indefinitely.
  - reqN_err is tied to 0 and the counter is absent.

## Test plan
- Port 0 write, addr 16'h005A, data 8'h55, addr_mem 1:
  - req0_ack is high one cycle after valid.
  - The master sees wr_en = 1, data_addr = 005A, wr_data = 55.
  - Model done after 50 cycles -> req0_done one cycle later, err 0.
- Port 1 read, addr 16'h005A, model returns 8'hA5:
  - rd_en = 1 during WAIT.
  - req1_rdata = A5 with req1_done.
  - req0 outputs stay 0.
- Both ports valid at the same edge after reset:
  - Port 0 is served first, then port 1.
  - Repeat with both continuously valid -> grants alternate 0,1,0,1.
- rst_n asserted during WAIT:
  - iic_start falls immediately.
  - No done pulse is issued.
  - After release, port 0 wins a simultaneous request.
- With IIC_ARB_TIMEOUT_EN and TIMEOUT_CYC = 16, model never completes:
  - reqN_done with err = 1 exactly 16 WAIT cycles after entry.
  - Next request is accepted normally.
- Stray iic_wr_rd_done pulse while IDLE:
  - No state change and no done output.
